stopwatch_core: RTL and testbench

- Millisecond stopwatch/countdown timer for the Nexys A7 100 MHz board.
- Counts up from 0, or down from a preset; the preset is either the hard-coded default or user-programmed in minutes and seconds.
- Drives the display path with `t` in milliseconds.
- Raises `zero` to the sound module when a countdown expires.

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/stopwatch_core_ms_tick_gen.sv | 38 +++
 rtl/stopwatch_core.sv | 139 +++++++++++++
 tb/tb_stopwatch_core.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the millisecond stopwatch/countdown core.
// sat_add clamps programmed and counted values to a ceiling.
package stopwatch_pkg;

    localparam int TIME_W     = 39;
    localparam int MS_PER_SEC = 1000;
    localparam int MS_PER_MIN = 60_000;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE,
        PROG
    } state_t;

    function automatic logic [TIME_W-1:0] sat_add(
        input logic [TIME_W-1:0] a,
        input logic [TIME_W-1:0] b,
        input logic [TIME_W-1:0] ceiling
    );
        logic [TIME_W-1:0] sum;
        sum = a + b;
        return (sum > ceiling) ? ceiling : sum;
    endfunction

endpackage

// File: rtl/stopwatch_core_ms_tick_gen.sv
// Millisecond tick divider: counts 0..TICK_DIV-1 while enabled and pulses
// tick on the terminal count. clr restarts the count so a fresh start gets a full period.
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/countdown core: edge detection, run/pause/program FSM and the
// time and preset registers. The preset survives rst and powers up as HCT_MS.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_DIV = CLK_HZ / 1000,
    parameter int HCT_MS   = 60_000,
    parameter int MAX_MS   = 5_999_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s,
    input  logic              p,
    input  logic              u,
    input  logic              inc,
    input  logic              min,
    output logic [TIME_W-1:0] t,
    output logic              zero
);

    localparam logic [TIME_W-1:0] HCT      = TIME_W'(HCT_MS);
    localparam logic [TIME_W-1:0] MAX      = TIME_W'(MAX_MS);
    localparam logic [TIME_W-1:0] STEP_SEC = TIME_W'(MS_PER_SEC);
    localparam logic [TIME_W-1:0] STEP_MIN = TIME_W'(MS_PER_MIN);

    state_t            state_q, state_d;
    logic [TIME_W-1:0] t_q, t_d;
    logic [TIME_W-1:0] preset_q = HCT;
    logic [TIME_W-1:0] preset_d;
    logic              zero_q, zero_d;
    logic              dir_q, dir_d;
    logic              s_q, s_prev_q, inc_q, inc_prev_q;
    logic              s_evt, inc_evt;
    logic              tick, tick_en, tick_clr;

    assign s_evt   = s_q & ~s_prev_q;
    assign inc_evt = inc_q & ~inc_prev_q;
    assign tick_en = (state_q == RUN);
    assign t       = t_q;
    assign zero    = zero_q;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (tick_clr),
        .tick(tick)
    );

    // p overrides everything except rst; a pause request on a countdown's final tick loses to DONE
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        preset_d = preset_q;
        dir_d    = dir_q;
        tick_clr = 1'b0;
        if (p) begin
            if (state_q != PROG) begin
                state_d  = PROG;
                preset_d = '0;
                t_d      = '0;
            end else begin
                if (inc_evt) begin
                    preset_d = sat_add(preset_q, min ? STEP_MIN : STEP_SEC, MAX);
                end
                t_d = preset_d;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    dir_d = u;
                    t_d   = u ? '0 : preset_q;
                    if (s_evt) begin
                        state_d  = RUN;
                        tick_clr = 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (dir_q) begin
                            t_d = (t_q >= MAX) ? MAX : t_q + 1'b1;
                        end else if (t_q <= 1) begin
                            t_d     = '0;
                            state_d = DONE;
                        end else begin
                            t_d = t_q - 1'b1;
                        end
                    end
                    if (s_evt && state_d == RUN) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (s_evt) begin
                        state_d  = RUN;
                        tick_clr = 1'b1;
                    end
                end
                DONE: begin
                    t_d = '0;
                end
                PROG: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        zero_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            t_q        <= '0;
            zero_q     <= 1'b0;
            dir_q      <= 1'b1;
            s_q        <= 1'b0;
            s_prev_q   <= 1'b0;
            inc_q      <= 1'b0;
            inc_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            zero_q     <= zero_d;
            dir_q      <= dir_d;
            preset_q   <= preset_d;
            s_q        <= s;
            s_prev_q   <= s_q;
            inc_q      <= inc;
            inc_prev_q <= inc_q;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: dut_a uses the default preset/ceiling,
// dut_b a tiny preset (3) and ceiling (10); both share inputs and TICK_DIV = 4.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s   = 1'b0;
    logic        p   = 1'b0;
    logic        u   = 1'b1;
    logic        inc = 1'b0;
    logic        min_sel = 1'b0;
    logic [38:0] t_a, t_b;
    logic        zero_a, zero_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_core #(
        .CLK_HZ(4000), .TICK_DIV(4), .HCT_MS(60_000), .MAX_MS(5_999_000)
    ) dut_a (
        .clk(clk), .rst(rst), .s(s), .p(p), .u(u), .inc(inc), .min(min_sel),
        .t(t_a), .zero(zero_a)
    );

    stopwatch_core #(
        .CLK_HZ(4000), .TICK_DIV(4), .HCT_MS(3), .MAX_MS(10)
    ) dut_b (
        .clk(clk), .rst(rst), .s(s), .p(p), .u(u), .inc(inc), .min(min_sel),
        .t(t_b), .zero(zero_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse on s or inc; returns one negedge later with the line low again
    task automatic applyStimulus(input bit do_s, input bit do_inc);
        s   = do_s;
        inc = do_inc;
        step(1);
        s   = 1'b0;
        inc = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(2);
        checkOutput("rst_t_a", 64'(t_a), 64'd0);
        checkOutput("rst_zero_b", 64'(zero_b), 64'd0);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        step(1);

        // Count up, pause, resume, reset
        u = 1'b1;
        doReset();
        checkOutput("idle_up_t", 64'(t_a), 64'd0);
        checkOutput("idle_up_zero", 64'(zero_a), 64'd0);
        applyStimulus(1'b1, 1'b0);
        step(4);
        checkOutput("up_before_tick", 64'(t_a), 64'd0);
        step(1);
        checkOutput("up_t1", 64'(t_a), 64'd1);
        step(4);
        checkOutput("up_t2", 64'(t_a), 64'd2);
        step(4);
        checkOutput("up_t3", 64'(t_a), 64'd3);
        applyStimulus(1'b1, 1'b0);
        step(8);
        checkOutput("pause_hold", 64'(t_a), 64'd3);
        applyStimulus(1'b1, 1'b0);
        step(4);
        checkOutput("resume_before_tick", 64'(t_a), 64'd3);
        step(1);
        checkOutput("resume_t4", 64'(t_a), 64'd4);
        doReset();
        checkOutput("reset_up_t", 64'(t_a), 64'd0);

        // Countdown from default preset, reset mid-run
        u = 1'b0;
        step(1);
        checkOutput("idle_down_preset", 64'(t_a), 64'd60000);
        applyStimulus(1'b1, 1'b0);
        step(5);
        checkOutput("down_t1", 64'(t_a), 64'd59999);
        step(4);
        checkOutput("down_t2", 64'(t_a), 64'd59998);
        doReset();
        checkOutput("reset_down_t", 64'(t_a), 64'd60000);
        checkOutput("reset_down_zero", 64'(zero_a), 64'd0);

        // Short countdown to DONE on dut_b
        checkOutput("b_idle_preset", 64'(t_b), 64'd3);
        applyStimulus(1'b1, 1'b0);
        step(5);
        checkOutput("b_t2", 64'(t_b), 64'd2);
        step(4);
        checkOutput("b_t1", 64'(t_b), 64'd1);
        step(3);
        checkOutput("b_zero_early", 64'(zero_b), 64'd0);
        step(1);
        checkOutput("b_t0", 64'(t_b), 64'd0);
        checkOutput("b_zero_set", 64'(zero_b), 64'd1);
        applyStimulus(1'b1, 1'b0);
        step(8);
        checkOutput("b_done_s_ignored_t", 64'(t_b), 64'd0);
        checkOutput("b_done_s_ignored_zero", 64'(zero_b), 64'd1);
        doReset();
        checkOutput("b_reset_zero", 64'(zero_b), 64'd0);
        checkOutput("b_reset_preset", 64'(t_b), 64'd3);

        // Program mode entered from RUN (dut_a) and DONE (dut_b)
        applyStimulus(1'b1, 1'b0);
        step(13);
        checkOutput("b_done_again", 64'(zero_b), 64'd1);
        p = 1'b1;
        step(1);
        checkOutput("prog_entry_t_a", 64'(t_a), 64'd0);
        checkOutput("prog_entry_t_b", 64'(t_b), 64'd0);
        checkOutput("prog_entry_zero_b", 64'(zero_b), 64'd0);
        applyStimulus(1'b1, 1'b0);
        step(8);
        checkOutput("prog_s_ignored", 64'(t_a), 64'd0);
        p = 1'b0;
        step(2);
        checkOutput("idle_preset_zero", 64'(t_a), 64'd0);
        applyStimulus(1'b1, 1'b0);
        step(4);
        checkOutput("zero_preset_before_tick", 64'(zero_a), 64'd0);
        step(1);
        checkOutput("zero_preset_done", 64'(zero_a), 64'd1);
        checkOutput("zero_preset_t", 64'(t_a), 64'd0);

        // Count-up saturation on dut_b
        u = 1'b1;
        doReset();
        applyStimulus(1'b1, 1'b0);
        step(40);
        checkOutput("sat_t9", 64'(t_b), 64'd9);
        step(1);
        checkOutput("sat_t10", 64'(t_b), 64'd10);
        step(8);
        checkOutput("sat_hold", 64'(t_b), 64'd10);

        // Program 2 min 3 s; dut_b saturates at its ceiling
        p = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            min_sel = (i < 2);
            applyStimulus(1'b0, 1'b1);
            step(1);
        end
        step(1);
        checkOutput("prog_value_a", 64'(t_a), 64'd123000);
        checkOutput("prog_sat_b", 64'(t_b), 64'd10);
        checkOutput("prog_zero_a", 64'(zero_a), 64'd0);
        p = 1'b0;
        u = 1'b0;
        step(1);
        doReset();
        checkOutput("prog_kept_a", 64'(t_a), 64'd123000);
        checkOutput("prog_kept_b", 64'(t_b), 64'd10);
        applyStimulus(1'b1, 1'b0);
        step(5);
        checkOutput("prog_down_t1", 64'(t_a), 64'd122999);
        step(4);
        checkOutput("prog_down_t2", 64'(t_a), 64'd122998);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
